// File: rtl/cpu_ctrl_pkg.sv
// Shared types and sizing for the accumulator CPU host-side control path.
// INSTR_W/PC_W are the core's defaults; the instruction ROM and PC size from these too.
package cpu_ctrl_pkg;
  localparam int INSTR_W = 9;
  localparam int PC_W    = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CORE_RST,
    S_RUN,
    S_DONE
  } ctrl_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Host sequencer for the accumulator core: streams a program into instruction memory,
// holds the core in reset, pulses req, then times the run until done or timeout.
module cpu_run_ctrl
  import cpu_ctrl_pkg::ctrl_state_t, cpu_ctrl_pkg::S_IDLE, cpu_ctrl_pkg::S_LOAD,
         cpu_ctrl_pkg::S_CORE_RST, cpu_ctrl_pkg::S_RUN, cpu_ctrl_pkg::S_DONE;
#(
  parameter int INSTR_W    = cpu_ctrl_pkg::INSTR_W,
  parameter int PC_W       = cpu_ctrl_pkg::PC_W,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               start,
  input  logic               core_done,
  output logic               imem_we,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_reset,
  output logic               core_req,
  output logic               busy,
  output logic               run_done,
  output logic               timed_out,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [PC_W:0]      prog_len
);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  ctrl_state_t        r_state;
  logic [PC_W:0]      r_wr_ptr;
  logic [PC_W:0]      r_prog_len;
  logic               r_imem_we;
  logic [PC_W-1:0]    r_imem_addr;
  logic [INSTR_W-1:0] r_imem_wdata;
  logic               r_run_done;
  logic               r_timed_out;
  logic               r_req_pend;
  logic [RC_W-1:0]    r_rst_cnt;

  logic               w_accept;
  logic               w_in_load;
  logic [PC_W:0]      w_base;
  logic               w_last_beat;
  logic               w_start_ok;
  logic               w_to_hit;
  logic               w_cnt_en;
  logic [CNT_W-1:0]   w_cycle_count;

  // A beat arriving in IDLE/DONE always starts a fresh program at address 0.
  assign w_accept    = load_valid && load_ready;
  assign w_in_load   = (r_state == S_LOAD);
  assign w_base      = w_in_load ? r_wr_ptr : '0;
  assign w_last_beat = load_last || (w_base[PC_W-1:0] == '1);
  assign w_start_ok  = start && !w_accept && (r_prog_len != '0) &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_to_hit    = (MAX_CYCLES != 0) && (w_cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign w_cnt_en    = (r_state == S_RUN) && !core_done && !w_to_hit;

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_start_ok),
    .i_en  (w_cnt_en),
    .o_cnt (w_cycle_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_prog_len   <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_run_done   <= 1'b0;
      r_timed_out  <= 1'b0;
      r_req_pend   <= 1'b0;
      r_rst_cnt    <= '0;
    end else begin
      r_imem_we <= w_accept;
      if (w_accept) begin
        r_imem_addr  <= w_base[PC_W-1:0];
        r_imem_wdata <= load_data;
        r_wr_ptr     <= w_base + (PC_W+1)'(1);
        if (w_last_beat) begin
          r_prog_len <= w_base + (PC_W+1)'(1);
          r_state    <= S_IDLE;
        end else begin
          if (!w_in_load)
            r_prog_len <= '0;
          r_state <= S_LOAD;
        end
      end else if (w_start_ok) begin
        // Rewinding the write pointer reopens loading after a full-depth program.
        r_run_done  <= 1'b0;
        r_timed_out <= 1'b0;
        r_wr_ptr    <= '0;
        r_rst_cnt   <= '0;
        r_state     <= S_CORE_RST;
      end else begin
        case (r_state)
          S_CORE_RST: begin
            if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
              r_req_pend <= 1'b1;
              r_state    <= S_RUN;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          S_RUN: begin
            r_req_pend <= 1'b0;
            if (core_done) begin
              r_run_done <= 1'b1;
              r_state    <= S_DONE;
            end else if (w_to_hit) begin
              r_timed_out <= 1'b1;
              r_state     <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    core_reset = 1'b1;
    core_req   = 1'b0;
    case (r_state)
      S_IDLE:     load_ready = !r_wr_ptr[PC_W];
      S_LOAD: begin
        load_ready = !r_wr_ptr[PC_W];
        busy       = 1'b1;
      end
      S_CORE_RST: busy = 1'b1;
      S_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        core_req   = r_req_pend;
      end
      S_DONE: begin
        load_ready = !r_wr_ptr[PC_W];
        core_reset = r_timed_out;
      end
      default: ;
    endcase
  end

  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign run_done    = r_run_done;
  assign timed_out   = r_timed_out;
  assign cycle_count = w_cycle_count;
  assign prog_len    = r_prog_len;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios then randomized traffic, every cycle
// compared against a behavioural model of the load/run sequencing rules.
module tb_cpu_run_ctrl;
  localparam int  IW      = 9;
  localparam int  PW      = 3;
  localparam int  CW      = 32;
  localparam int  RC      = 2;
  localparam int  MC      = 16;
  localparam int  DEPTH   = 8;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          start = 1'b0;
  logic          core_done = 1'b0;
  logic          imem_we;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          core_reset;
  logic          core_req;
  logic          busy;
  logic          run_done;
  logic          timed_out;
  logic [CW-1:0] cycle_count;
  logic [PW:0]   prog_len;

  cpu_run_ctrl #(
    .INSTR_W(IW), .PC_W(PW), .CNT_W(CW), .RST_CYCLES(RC), .MAX_CYCLES(MC)
  ) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .core_done(core_done),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .core_req(core_req), .busy(busy), .run_done(run_done),
    .timed_out(timed_out), .cycle_count(cycle_count), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phases described by what the core is doing, not by FSM states.
  bit     m_loading, m_running, m_first, m_fin, m_we, m_rd, m_to;
  int     m_rst_left, m_ptr, m_len, m_waddr, m_wdata;
  longint m_cnt;

  function automatic bit m_holding();
    return (m_rst_left > 0) || m_running;
  endfunction

  function automatic bit m_ready();
    return !m_holding() && (m_ptr < DEPTH);
  endfunction

  function automatic bit m_core_reset();
    if (m_running) return 1'b0;
    if (m_fin) return m_to;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_loading = 0; m_running = 0; m_first = 0; m_fin = 0; m_we = 0; m_rd = 0; m_to = 0;
    m_rst_left = 0; m_ptr = 0; m_len = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit lv, input int ld, input bit ll, input bit st, input bit cd);
    bit acc;
    int base;
    acc  = lv && m_ready();
    m_we = acc;
    if (acc) begin
      base = m_loading ? m_ptr : 0;
      if (!m_loading) m_len = 0;
      m_waddr = base; m_wdata = ld; m_ptr = base + 1; m_fin = 0; m_loading = 1;
      if (ll || base == DEPTH - 1) begin
        m_len = base + 1;
        m_loading = 0;
      end
    end else if (st && !m_loading && !m_holding() && m_len != 0) begin
      m_rd = 0; m_to = 0; m_cnt = 0; m_ptr = 0; m_fin = 0; m_rst_left = RC;
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) begin
        m_running = 1; m_first = 1;
      end
    end else if (m_running) begin
      m_first = 0;
      if (cd) begin
        m_running = 0; m_fin = 1; m_rd = 1;
      end else if (m_cnt == MC - 1) begin
        m_running = 0; m_fin = 1; m_to = 1;
      end else if (m_cnt < CNT_MAX) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_all();
    check("busy",        busy,        m_holding() || m_loading);
    check("load_ready",  load_ready,  m_ready());
    check("core_reset",  core_reset,  m_core_reset());
    check("core_req",    core_req,    m_running && m_first);
    check("run_done",    run_done,    m_rd);
    check("timed_out",   timed_out,   m_to);
    check("cycle_count", cycle_count, m_cnt);
    check("prog_len",    prog_len,    m_len);
    check("imem_we",     imem_we,     m_we);
    if (m_we) begin
      check("imem_addr",  imem_addr,  m_waddr);
      check("imem_wdata", imem_wdata, m_wdata);
    end
  endtask

  task automatic cyc(input bit lv, input int ld, input bit ll, input bit st, input bit cd);
    load_valid = lv; load_data = IW'(ld); load_last = ll; start = st; core_done = cd;
    @(posedge clk);
    model_step(lv, ld, ll, st, cd);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_core_reset", core_reset, 1);
    check("rst_busy",       busy,       0);
    check("rst_prog_len",   prog_len,   0);
    check("rst_imem_we",    imem_we,    0);
    check("rst_cycle_cnt",  cycle_count, 0);
    check("rst_load_ready", load_ready, 1);
    reset = 1'b1;

    // start with no program loaded
    cyc(0, 0, 0, 1, 0);
    check("nostart_busy", busy, 0);
    check("nostart_req",  core_req, 0);

    // 3-word program, with a start attempt mid-load
    cyc(1, 'h1A5, 0, 0, 0);
    check("ld0_addr", imem_addr, 0); check("ld0_data", imem_wdata, 'h1A5);
    cyc(0, 0, 0, 1, 0);
    check("ldstart_busy", busy, 1); check("ldstart_we", imem_we, 0);
    cyc(1, 'h003, 0, 1, 0);
    check("ld1_addr", imem_addr, 1); check("ld1_data", imem_wdata, 'h003);
    cyc(1, 'h100, 1, 0, 0);
    check("ld2_addr", imem_addr, 2); check("ld2_data", imem_wdata, 'h100);
    check("ld_prog_len", prog_len, 3);

    // run finishing on 10th RUN cycle
    cyc(0, 0, 0, 1, 0);
    check("crst1", core_reset, 1);
    cyc(0, 0, 0, 0, 0);
    check("crst2", core_reset, 1); check("crst2_req", core_req, 0);
    cyc(0, 0, 0, 0, 0);
    check("run1_req", core_req, 1); check("run1_rst", core_reset, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("ok_run_done", run_done, 1); check("ok_count", cycle_count, 9);
    check("ok_core_rst", core_reset, 0); check("ok_busy", busy, 0);

    // timeout at MAX_CYCLES
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < RC + 16; i++) cyc(0, 0, 0, 0, 0);
    check("to_flag", timed_out, 1); check("to_count", cycle_count, 15);
    check("to_core_rst", core_reset, 1); check("to_run_done", run_done, 0);

    // done on the timeout cycle wins
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < RC + 15; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("tie_done", run_done, 1); check("tie_to", timed_out, 0);
    check("tie_count", cycle_count, 15);

    // asynchronous reset mid-RUN
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < RC + 3; i++) cyc(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_core_reset", core_reset, 1); check("arst_busy", busy, 0);
    check("arst_prog_len", prog_len, 0);     check("arst_req", core_req, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    check_all();

    // full-depth program without load_last
    for (int i = 0; i < DEPTH; i++) cyc(1, $urandom_range(0, 511), 0, 0, 0);
    check("full_ready", load_ready, 0); check("full_len", prog_len, DEPTH);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < RC; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("full_done", run_done, 1);
    cyc(1, 'h0AB, 0, 1, 0);
    check("dn_ld_busy", busy, 1); check("dn_ld_req", core_req, 0);
    check("dn_ld_we", imem_we, 1); check("dn_ld_addr", imem_addr, 0);
    check("dn_ld_len", prog_len, 0);
    cyc(0, 0, 0, 0, 0);
    check("dn_ld_rst", core_reset, 1);
    cyc(1, 'h055, 1, 0, 0);
    check("dn_ld_len2", prog_len, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 35, $urandom_range(0, 511), $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
